// File: rtl/axis_src_defs_pkg.sv
// Shared definitions for the AXI4-Stream frame source: FSM state encoding,
// LFSR seed/taps used by the optional stall generator, frame counter width,
// and the sideband flags that travel alongside each pixel.
package axis_src_defs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_GAP   = 2'd2,
    ST_DRAIN = 2'd3
  } src_state_e;

  localparam int FRAME_CNT_W = 16;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bit indices 15,13,12,10).
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Flags computed when a read is issued; they ride with the returned data.
  // flast marks the last pixel of a frame independently of the tlast mode.
  typedef struct packed {
    logic flast;
    logic tlast;
    logic tuser;
  } beat_side_t;

  localparam int SIDE_W = $bits(beat_side_t);

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/axis_skid2.sv
// Two-entry output buffer for the frame source. The head entry drives the
// stream outputs directly, so the payload is stable while the sink stalls.
// flush_i empties the buffer and wins over a simultaneous push/pop.
module axis_skid2 #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  // Qualify push/pop: never pop empty, push into a full buffer only if a pop frees a slot.
  always_comb begin
    do_pop  = pop_i && (count_q != 2'd0);
    do_push = push_i && ((count_q != 2'd2) || do_pop);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/axis_frame_source.sv
// AXI4-Stream pixel frame source. Reads a FRAME_W x FRAME_H raster from a
// synchronous memory (1-cycle latency) and streams it with backpressure,
// tuser on the first pixel of a frame and tlast per last_mode.
// Optional stall generator: define AXIS_SRC_STALL_LFSR_EN to add the stall_en
// input and an LFSR that suppresses read issue pseudo-randomly.
//
// Handshake: a beat transfers on a rising edge where m_axis_tvalid and
// m_axis_tready are both high; tvalid never drops and the payload never
// changes while tvalid is high and tready is low.
module axis_frame_source
  import axis_src_defs_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int FRAME_W = 1024,
  parameter int FRAME_H = 1025,
  parameter int GAP_W   = 8,
  parameter int ADDR_W  = $clog2(FRAME_W * FRAME_H)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   loop_en,
  input  logic                   last_mode,
  input  logic [GAP_W-1:0]       line_gap,
`ifdef AXIS_SRC_STALL_LFSR_EN
  input  logic                   stall_en,
`endif
  output logic                   mem_en,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic [DATA_W-1:0]      m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tuser,
  output logic                   m_axis_tlast,
  output logic                   busy,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int COL_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int ROW_W = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(FRAME_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_H - 1);
  localparam int PL_W = DATA_W + SIDE_W;

  src_state_e       state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             lmode_q, lmode_d;

  logic             pend_q;
  beat_side_t       side_q, side_d;

  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic             frame_done_q;

  logic [PL_W-1:0]  fifo_head;
  logic [1:0]       fifo_count;
  beat_side_t       head_side;
  logic             fifo_pop;
  logic [2:0]       inflight;
  logic             credit_ok;
  logic             stall;
  logic             issue;
  logic             start_ok;
  logic             col_last;
  logic             row_last;
  logic             drain_done;

`ifdef AXIS_SRC_STALL_LFSR_EN
  logic [15:0] lfsr_q;

  // Stall generator: reseeded on start, free-runs while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else if (start_ok) begin
      lfsr_q <= LFSR_SEED;
    end else if (state_q != ST_IDLE) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign stall = stall_en & lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // Issue control: reads are allowed while buffered + in-flight beats,
  // less the beat leaving this cycle, stay below the buffer depth.
  always_comb begin
    fifo_pop   = (fifo_count != 2'd0) && m_axis_tready;
    inflight   = {1'b0, fifo_count} + {2'b00, pend_q} - {2'b00, fifo_pop};
    credit_ok  = inflight < 3'd2;
    issue      = (state_q == ST_RUN) && credit_ok && !stall && !abort;
    start_ok   = (state_q == ST_IDLE) && start && !abort;
    col_last   = (col_q == COL_LAST);
    row_last   = (row_q == ROW_LAST);
    drain_done = !pend_q &&
                 ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && fifo_pop));
  end

  // Sideband flags for the pixel being issued this cycle.
  always_comb begin
    side_d       = '0;
    side_d.tuser = (col_q == '0) && (row_q == '0);
    side_d.flast = col_last && row_last;
    side_d.tlast = lmode_q ? col_last : (col_last && row_last);
  end

  // Next-state: raster walk, line gaps, frame wrap/drain; abort overrides all.
  // addr tracks row*FRAME_W+col incrementally instead of multiplying.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    gap_d   = gap_q;
    lmode_d = lmode_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_RUN;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
          lmode_d = last_mode;
        end
      end
      ST_RUN: begin
        if (issue) begin
          if (col_last) begin
            col_d   = '0;
            lmode_d = last_mode;
            if (row_last) begin
              row_d  = '0;
              addr_d = '0;
            end else begin
              row_d  = row_q + ROW_W'(1);
              addr_d = addr_q + ADDR_W'(1);
            end
            if (row_last && !loop_en) begin
              state_d = ST_DRAIN;
            end else if (line_gap != '0) begin
              state_d = ST_GAP;
              gap_d   = line_gap;
            end
          end else begin
            col_d  = col_q + COL_W'(1);
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      ST_GAP: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_q <= GAP_W'(1)) begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      col_d   = '0;
      row_d   = '0;
      addr_d  = '0;
      gap_d   = '0;
    end
  end

  // FSM and raster position registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      gap_q   <= '0;
      lmode_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      gap_q   <= gap_d;
      lmode_q <= lmode_d;
    end
  end

  // Read pipeline: remember which cycle's read returns data and its flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
      side_q <= '0;
    end else begin
      pend_q <= issue;
      if (issue) begin
        side_q <= side_d;
      end
    end
  end

  axis_skid2 #(
    .W(PL_W)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (abort),
    .push_i     (pend_q),
    .push_data_i({side_q, mem_rdata}),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .count_o    (fifo_count)
  );

  assign head_side = beat_side_t'(fifo_head[PL_W-1 -: SIDE_W]);

  // Frame completion: counted on the edge accepting the frame-last pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= !abort && fifo_pop && head_side.flast;
      if (start_ok) begin
        frame_cnt_q <= '0;
      end else if (!abort && fifo_pop && head_side.flast) begin
        frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
      end
    end
  end

  assign mem_en        = issue;
  assign mem_addr      = addr_q;
  assign m_axis_tdata  = fifo_head[DATA_W-1:0];
  assign m_axis_tvalid = (fifo_count != 2'd0);
  assign m_axis_tuser  = head_side.tuser;
  assign m_axis_tlast  = head_side.tlast;
  assign busy          = (state_q != ST_IDLE);
  assign frame_done    = frame_done_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_axis_frame_source.sv
// Bench for axis_frame_source with a 4x3 frame; memory returns addr[7:0].
`timescale 1ns/1ps
module tb_axis_frame_source;

  localparam int DATA_W  = 8;
  localparam int FRAME_W = 4;
  localparam int FRAME_H = 3;
  localparam int GAP_W   = 8;
  localparam int ADDR_W  = 4;
  localparam int NPIX    = FRAME_W * FRAME_H;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, abort = 1'b0, loop_en = 1'b0, last_mode = 1'b0;
  logic [GAP_W-1:0] line_gap = '0;
  logic mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [DATA_W-1:0] tdata;
  logic tvalid, tuser, tlast, busy, frame_done;
  logic tready = 1'b0;
  logic [15:0] frame_cnt;
`ifdef AXIS_SRC_STALL_LFSR_EN
  logic stall_en = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  bit stall_on = 1'b0;
  bit vpat[1024];
  int vlen;

  always #5 clk = ~clk;

  // Synchronous memory, one cycle latency, returns the low address byte.
  always @(posedge clk) if (mem_en) mem_rdata <= DATA_W'(mem_addr);

  axis_frame_source #(
    .DATA_W(DATA_W), .FRAME_W(FRAME_W), .FRAME_H(FRAME_H),
    .GAP_W(GAP_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .loop_en(loop_en), .last_mode(last_mode), .line_gap(line_gap),
`ifdef AXIS_SRC_STALL_LFSR_EN
    .stall_en(stall_en),
`endif
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tuser(tuser), .m_axis_tlast(tlast),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  // ---------------- scoreboard ----------------
  logic [DATA_W+1:0] exp_q[$];   // {tlast, tuser, tdata}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference stream straight from the raster definition.
  task automatic build_model(input int nframes, input bit lmode);
    exp_q.delete();
    for (int f = 0; f < nframes; f++)
      for (int r = 0; r < FRAME_H; r++)
        for (int c = 0; c < FRAME_W; c++) begin
          logic lst, usr;
          usr = (r == 0) && (c == 0);
          lst = lmode ? (c == FRAME_W - 1) : ((c == FRAME_W - 1) && (r == FRAME_H - 1));
          exp_q.push_back({lst, usr, DATA_W'(r * FRAME_W + c)});
        end
  endtask

  function automatic logic pick_ready(input int mode, input int cyc);
    case (mode)
      0: return 1'b1;
      1: return ((cyc % 5) == 0) || ((cyc % 5) == 3);
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  typedef struct {
    int gap;
    int nframes;
    bit lmode;
    int rmode;      // 0 always ready, 1 pattern 1,0,0,1,0, 2 random
    bit poke;       // pulse start mid-frame (must be ignored)
    int exp_beats;
    int exp_cnt;
  } vec_t;

  task automatic run_scn(input vec_t v, input string tag);
    int beats, cyc, lowrun, first_cyc, done_cnt;
    bit prev_stall, exp_done;
    logic [DATA_W+1:0] prev_pl, act_pl, exp_pl;
    build_model(v.nframes, v.lmode);
    line_gap  = GAP_W'(v.gap);
    last_mode = v.lmode;
    loop_en   = (v.nframes > 1);
    @(posedge clk); #1;
    start = 1'b1;
    tready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    beats = 0; cyc = 0; lowrun = 0; first_cyc = -1; done_cnt = 0;
    prev_stall = 1'b0; exp_done = 1'b0; prev_pl = '0;
    while ((beats < v.exp_beats || exp_done) && cyc < 2000) begin
      tready = pick_ready(v.rmode, cyc);
      start  = v.poke && (beats == 6);
      if (v.nframes > 1 && beats >= (v.nframes - 1) * NPIX) loop_en = 1'b0;
      @(negedge clk);
      if (cyc < 1024) vpat[cyc] = tvalid;
      chk({tag, " frame_done"}, frame_done, exp_done);
      if (frame_done) done_cnt++;
      exp_done = 1'b0;
      if (prev_stall) begin
        chk({tag, " hold_valid"}, tvalid, 1);
        chk({tag, " hold_payload"}, {tlast, tuser, tdata}, prev_pl);
      end
      if (beats < v.exp_beats) chk({tag, " busy_high"}, busy, 1);
      else chk({tag, " busy_low"}, busy, 0);
      if (tvalid && first_cyc < 0) begin
        first_cyc = cyc;
        if (!stall_on) chk({tag, " first_latency"}, cyc, 2);
      end
      if (tvalid && tready && beats < v.exp_beats) begin
        act_pl = {tlast, tuser, tdata};
        exp_pl = exp_q.pop_front();
        chk($sformatf("%s beat%0d", tag, beats), act_pl, exp_pl);
        if (v.rmode == 0 && !stall_on && beats > 0)
          chk($sformatf("%s bubbles%0d", tag, beats), lowrun,
              ((beats % FRAME_W) == 0) ? v.gap : 0);
        lowrun = 0;
        if ((beats % NPIX) == NPIX - 1) exp_done = 1'b1;
        beats++;
      end else if (first_cyc >= 0 && !tvalid) begin
        lowrun++;
      end
      prev_stall = tvalid && !tready;
      prev_pl    = {tlast, tuser, tdata};
      @(posedge clk); #1;
      cyc++;
    end
    vlen = cyc;
    start = 1'b0;
    chk({tag, " no_timeout"}, (cyc < 2000), 1);
    chk({tag, " beat_count"}, beats, v.exp_beats);
    chk({tag, " done_count"}, done_cnt, v.nframes);
    chk({tag, " frame_cnt"}, frame_cnt, v.exp_cnt);
    chk({tag, " model_empty"}, exp_q.size(), 0);
    tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk({tag, " idle_tvalid"}, tvalid, 0);
      chk({tag, " idle_mem_en"}, mem_en, 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_accepts(input int n, input string tag);
    int got, cyc;
    got = 0; cyc = 0;
    while (got < n && cyc < 500) begin
      @(negedge clk);
      if (tvalid && tready) got++;
      cyc++;
      @(posedge clk); #1;
    end
    chk({tag, " reached"}, got, n);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[8];
  vec_t vrep;

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 1, 1'b0, 0, 1'b0, 12, 1};
    vecs[1] = '{2, 1, 1'b0, 0, 1'b0, 12, 1};
    vecs[2] = '{0, 1, 1'b0, 1, 1'b0, 12, 1};
    vecs[3] = '{0, 3, 1'b1, 0, 1'b0, 36, 3};
    vecs[4] = '{int'($urandom_range(0, 3)), 2, 1'b0, 2, 1'b0, 24, 2};
    vecs[5] = '{int'($urandom_range(0, 3)), 2, 1'b1, 2, 1'b0, 24, 2};
    vecs[6] = '{1, 1, 1'b0, 0, 1'b1, 12, 1};
    vecs[7] = '{3, 2, 1'b1, 1, 1'b0, 24, 2};
    vrep    = '{0, 1, 1'b0, 0, 1'b0, 12, 1};

    // Reset: outputs must be quiescent.
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst tvalid", tvalid, 0);
    chk("rst mem_en", mem_en, 0);
    chk("rst busy", busy, 0);
    chk("rst frame_cnt", frame_cnt, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst mem_addr", mem_addr, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_scn(vecs[i], $sformatf("vec%0d", i));

    // Abort in frame 2 at beat 5 with tready low.
    loop_en = 1'b1; line_gap = '0; last_mode = 1'b0; tready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_accepts(17, "abort_wait");
    tready = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    chk("pre_abort tvalid", tvalid, 1);
    @(posedge clk); #1;
    abort = 1'b0;
    loop_en = 1'b0;
    @(negedge clk);
    chk("abort tvalid", tvalid, 0);
    chk("abort mem_en", mem_en, 0);
    chk("abort busy", busy, 0);
    chk("abort frame_cnt", frame_cnt, 1);
    chk("abort frame_done", frame_done, 0);
    @(posedge clk); #1;
    run_scn(vrep, "replay");

    // Abort wins over a simultaneous start.
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("abort_start busy", busy, 0);
    chk("abort_start mem_en", mem_en, 0);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of frame 2.
    loop_en = 1'b1; tready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_accepts(14, "rst_wait");
    @(negedge clk);
    chk("pre_rst frame_cnt", frame_cnt, 1);
    chk("pre_rst tvalid", tvalid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst tvalid", tvalid, 0);
    chk("arst mem_en", mem_en, 0);
    chk("arst mem_addr", mem_addr, 0);
    chk("arst tdata", tdata, 0);
    chk("arst tuser", tuser, 0);
    chk("arst tlast", tlast, 0);
    chk("arst busy", busy, 0);
    chk("arst frame_done", frame_done, 0);
    chk("arst frame_cnt", frame_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    loop_en = 1'b0;
    run_scn(vrep, "post_rst");

`ifdef AXIS_SRC_STALL_LFSR_EN
    begin
      int base_len, len1;
      bit pat1[1024];
      int diffs;
      run_scn(vrep, "stall_base");
      base_len = vlen;
      stall_on = 1'b1;
      stall_en = 1'b1;
      run_scn(vrep, "stall_run1");
      len1 = vlen;
      for (int i = 0; i < 1024; i++) pat1[i] = vpat[i];
      run_scn(vrep, "stall_run2");
      chk("stall repeat_len", vlen, len1);
      diffs = 0;
      for (int i = 0; i < len1 && i < 1024; i++) if (pat1[i] != vpat[i]) diffs++;
      chk("stall repeat_pattern", diffs, 0);
      chk("stall bubbles_seen", (len1 > base_len), 1);
      stall_en = 1'b0;
      stall_on = 1'b0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_frame_source.md
Name: axis_frame_source

Overview:
- Parametrised, synthesizable AXI4-Stream pixel frame source; successor to the fixed 8-bit, free-running stimulus path that feeds top_core.
- Reads a FRAME_W x FRAME_H raster from an external synchronous memory (1-cycle read latency) and streams it with full valid/ready backpressure, start-of-frame and end-of-line/frame markers.
- Supports programmable inter-line gaps, looping and abort.
- Drives top_core in simulation and on-board self-test.

Parameters:
- DATA_W, 8, pixel width in bits.
- FRAME_W, 1024, pixels per line.
- FRAME_H, 1025, lines per frame.
- GAP_W, 8, width of line_gap.
- ADDR_W, $clog2(FRAME_W*FRAME_H), memory address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin streaming at pixel 0; ignored while busy.
- abort  in  1  stop immediately and flush.
- loop_en  in  1  restart at pixel 0 after the last pixel.
- last_mode  in  1  0: tlast on last pixel of frame; 1: tlast on last pixel of every line.
- line_gap  in  GAP_W  idle read cycles inserted after each line.
- mem_en  out  1  read strobe.
- mem_addr  out  ADDR_W  read address, raster order.
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_en.
- m_axis_tdata  out  DATA_W  pixel.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  sink ready.
- m_axis_tuser  out  1  first pixel of frame.
- m_axis_tlast  out  1  per last_mode.
- busy  out  1  high from start until the final beat is accepted or abort.
- frame_done  out  1  one-cycle pulse on acceptance of the last pixel of a frame.
- frame_cnt  out  16  completed frames since start; wraps.

Behaviour:
- Reset: every output 0, state IDLE, buffer empty, counters 0. Reset is asynchronous, so it takes effect mid-frame without waiting for a clock edge.
- FSM states: IDLE, RUN, GAP, DRAIN.
- IDLE → RUN on start.
  - At the same edge: mem_en=1, mem_addr=0, busy=1, frame_cnt=0.
  - First tvalid appears 2 edges later.
- RUN:
  - Issues one read per cycle while (buffer occupancy + reads in flight) < 2.
  - Advances col/row; mem_addr = row*FRAME_W + col.
- Line end: after issuing col=FRAME_W-1:
  - If line_gap≠0, enter GAP for exactly line_gap cycles with mem_en=0, then return to RUN.
  - If line_gap=0, no gap.
- Frame end: after issuing the last pixel of the frame:
  - loop_en=1: wrap to addr 0. The frame boundary is also a line boundary and gets line_gap.
  - loop_en=0: enter DRAIN.
- DRAIN → IDLE when the buffer is empty and the last beat has been accepted; busy falls the same edge.
- Output buffer: 2-entry FIFO; the head drives tdata/tuser/tlast.
  - tvalid = not empty.
  - Pop on tvalid & tready.
  - Sustains 1 beat/cycle under continuous tready.
  - tdata/tuser/tlast held stable while tvalid & !tready.
  - Sideband flags are computed at read issue and travel with the data.
- frame_done and the frame_cnt increment occur on the edge that accepts the frame-last pixel, regardless of last_mode.
- abort, in any state:
  - Next edge: IDLE, buffer flushed, any in-flight read discarded, tvalid=0, mem_en=0, busy=0.
  - frame_cnt is held.
  - abort has priority over a simultaneous start.
- start while busy: ignored.
- loop_en and last_mode are sampled at each frame or line boundary. line_gap is sampled when entering GAP.

Optional Feature:
- Macro: AXIS_SRC_STALL_LFSR_EN.
- When defined:
  - Adds input stall_en (1 bit) and a 16-bit Fibonacci LFSR with taps 16,14,13,11 and seed 16'hACE1.
  - The LFSR advances every cycle while busy.
  - When stall_en=1 and lfsr[0]=1, read issue is suppressed that cycle, producing pseudo-random tvalid bubbles.
  - The LFSR reseeds on start.
- When undefined: no port, no LFSR, behaviour as above.

Decomposition:
- Shared header axis_src_defs: FSM state encodings, LFSR seed and taps, frame_cnt width.
- One sub-module, axis_skid2: the 2-entry buffer with push, pop, flush, occupancy and data+tuser+tlast payload.
- Top level holds the FSM, counters, gap timer and memory port.

Test Plan:
- Common setup for all scenarios: FRAME_W=4, FRAME_H=3; memory returns addr[7:0].
- Single frame: tready=1, line_gap=0, loop_en=0, start pulse
  → beats 0..11 back-to-back, first tvalid 2 edges after start, tuser on beat 0, tlast on beat 11, one frame_done pulse, frame_cnt=1, busy low after beat 11.
- Line gap: line_gap=2
  → exactly 2 tvalid-low cycles between beats 3/4 and 7/8; data still 0..11.
- Backpressure: tready pattern 1,0,0,1,0 repeating
  → tdata stable during every stall; no loss or duplication; 12 beats in order.
- Loop and markers: loop_en=1 for 3 frames, cleared during frame 3, last_mode=1
  → tuser on beats 0,12,24; tlast on every 4th beat; frame_cnt=3; stops after beat 35.
- Abort: abort at beat 5 with tready=0
  → next cycle tvalid=0, mem_en=0, busy=0.
  - A subsequent start replays from pixel 0.
  - Same check with rst asserted mid-frame: all outputs 0 without waiting for a clock edge.
- With AXIS_SRC_STALL_LFSR_EN and stall_en=1, tready=1
  → bubbles occur, sequence stays 0..11, and two runs give identical tvalid patterns.
